// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen bus slave port between several hosts.
// One transaction is outstanding at a time; the response is routed back to its owner only.
module rggen_bus_arbiter #(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [HOSTS-1:0]               i_host_write,
  input  logic [HOSTS*BUS_WIDTH-1:0]     i_host_write_data,
  input  logic [HOSTS*BUS_WIDTH/8-1:0]   i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output logic [HOSTS*2-1:0]             o_host_status,
  output logic [HOSTS*BUS_WIDTH-1:0]     o_host_read_data,
  output logic                           o_valid,
  output logic [ADDRESS_WIDTH-1:0]       o_address,
  output logic                           o_write,
  output logic [BUS_WIDTH-1:0]           o_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_strobe,
  input  logic                           i_ready,
  input  logic [1:0]                     i_status,
  input  logic [BUS_WIDTH-1:0]           i_read_data,
  output logic [HOSTS-1:0]               o_grant
);

  localparam int SW = BUS_WIDTH / 8;
  localparam int IW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                   state;
  logic [IW-1:0]            last;
  logic [IW-1:0]            owner;
  logic                     found;
  logic [IW-1:0]            pick;
  logic [IW:0]              idx;
  logic                     hit;
  logic [HOSTS-1:0]         pick_onehot;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic                     sel_write;
  logic [BUS_WIDTH-1:0]     sel_write_data;
  logic [SW-1:0]            sel_strobe;

  // Round-robin search: first valid host after the last owner, wrapping modulo HOSTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int i = 1; i <= HOSTS; i++) begin
      idx   = {1'b0, last} + (IW+1)'(i);
      idx   = (idx >= (IW+1)'(HOSTS)) ? idx - (IW+1)'(HOSTS) : idx;
      hit   = !found && i_host_valid[idx[IW-1:0]];
      pick  = hit ? idx[IW-1:0] : pick;
      found = found | hit;
    end
  end

  // Multiplex the chosen host's request fields and build its one-hot grant.
  always_comb begin
    sel_address    = '0;
    sel_write      = 1'b0;
    sel_write_data = '0;
    sel_strobe     = '0;
    pick_onehot    = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if (pick == IW'(h)) begin
        sel_address    = i_host_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write      = i_host_write[h];
        sel_write_data = i_host_write_data[h*BUS_WIDTH +: BUS_WIDTH];
        sel_strobe     = i_host_strobe[h*SW +: SW];
        pick_onehot[h] = found;
      end else begin
        pick_onehot[h] = 1'b0;
      end
    end
  end

  // Arbitration FSM; request fields are captured once at grant and held until i_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      last         <= IW'(HOSTS - 1);
      owner        <= '0;
      o_valid      <= 1'b0;
      o_grant      <= '0;
      o_address    <= '0;
      o_write      <= 1'b0;
      o_write_data <= '0;
      o_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state        <= BUSY;
            owner        <= pick;
            o_valid      <= 1'b1;
            o_grant      <= pick_onehot;
            o_address    <= sel_address;
            o_write      <= sel_write;
            o_write_data <= sel_write_data;
            o_strobe     <= sel_strobe;
          end
        end
        BUSY: begin
          if (i_ready) begin
            state   <= IDLE;
            last    <= owner;
            o_valid <= 1'b0;
            o_grant <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_grant <= '0;
        end
      endcase
    end
  end

  // Route the downstream response to the owning host only; everything else reads zero.
  always_comb begin
    o_host_ready     = '0;
    o_host_status    = '0;
    o_host_read_data = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if ((state == BUSY) && o_grant[h]) begin
        o_host_ready[h]                           = i_ready;
        o_host_status[h*2 +: 2]                   = i_status;
        o_host_read_data[h*BUS_WIDTH +: BUS_WIDTH] = i_read_data;
      end else begin
        o_host_ready[h]                           = 1'b0;
        o_host_status[h*2 +: 2]                   = 2'b00;
        o_host_read_data[h*BUS_WIDTH +: BUS_WIDTH] = '0;
      end
    end
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter: a 2-host instance for the main scenarios
// and a 3-host instance for the round-robin wrap case.
module tb_rggen_bus_arbiter;

  logic        clk;
  logic        rst;
  int          vectors;
  int          miscompares;

  // 2-host instance
  logic [1:0]  hv, hwe, hr, grant;
  logic [15:0] haddr;
  logic [63:0] hwd, hrd;
  logic [7:0]  hstb;
  logic [3:0]  hst;
  logic        ov, owr, rdy;
  logic [7:0]  oaddr;
  logic [31:0] owd, rd;
  logic [3:0]  ostb;
  logic [1:0]  st;

  // 3-host instance
  logic [2:0]  h3v, h3we, h3r, g3;
  logic [23:0] h3addr;
  logic [95:0] h3wd, h3rd;
  logic [11:0] h3stb;
  logic [5:0]  h3st;
  logic        ov3, owr3, rdy3;
  logic [7:0]  oaddr3;
  logic [31:0] owd3;
  logic [3:0]  ostb3;

  rggen_bus_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(hv), .i_host_address(haddr), .i_host_write(hwe),
    .i_host_write_data(hwd), .i_host_strobe(hstb),
    .o_host_ready(hr), .o_host_status(hst), .o_host_read_data(hrd),
    .o_valid(ov), .o_address(oaddr), .o_write(owr), .o_write_data(owd), .o_strobe(ostb),
    .i_ready(rdy), .i_status(st), .i_read_data(rd), .o_grant(grant)
  );

  rggen_bus_arbiter #(.HOSTS(3), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(h3v), .i_host_address(h3addr), .i_host_write(h3we),
    .i_host_write_data(h3wd), .i_host_strobe(h3stb),
    .o_host_ready(h3r), .o_host_status(h3st), .o_host_read_data(h3rd),
    .o_valid(ov3), .o_address(oaddr3), .o_write(owr3), .o_write_data(owd3), .o_strobe(ostb3),
    .i_ready(rdy3), .i_status(2'b00), .i_read_data(32'h0), .o_grant(g3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_g [8];

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    hv = '0; hwe = '0; haddr = '0; hwd = '0; hstb = '0;
    rdy = 1'b0; st = 2'b00; rd = '0;
    h3v = '0; h3we = '0; h3addr = '0; h3wd = '0; h3stb = '0; rdy3 = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", ov, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_addr", oaddr, 8'h00);
    chk("rst_write", owr, 1'b0);
    chk("rst_wdata", owd, 32'h0);
    chk("rst_strobe", ostb, 4'h0);
    chk("rst_grant3", g3, 3'b000);

    // 1: single read by host0, ready on third BUSY cycle
    hv = 2'b01; haddr = 16'h0010; hwe = 2'b00;
    step();
    chk("t1_valid_c1", ov, 1'b1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_addr", oaddr, 8'h10);
    chk("t1_write", owr, 1'b0);
    chk("t1_hready_c1", hr, 2'b00);
    step();
    chk("t1_valid_c2", ov, 1'b1);
    chk("t1_hready_c2", hr, 2'b00);
    step();
    rdy = 1'b1; st = 2'b00; rd = 32'hCAFE0001;
    #1;
    chk("t1_valid_c3", ov, 1'b1);
    chk("t1_hready_c3", hr, 2'b01);
    chk("t1_hrdata", hrd, {32'h0, 32'hCAFE0001});
    chk("t1_hstatus", hst, 4'h0);
    step();
    hv = 2'b00;
    #1;
    chk("t1_idle_valid", ov, 1'b0);
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_hready", hr, 2'b00);
    chk("t1_idle_hrdata", hrd, 64'h0);
    rdy = 1'b0;

    // 2: both hosts valid, 1-cycle ready; last owner is host0 so host1 leads
    exp_g = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    hv = 2'b11; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2_grant_%0d", i), grant, exp_g[i]);
      chk($sformatf("t2_hready_%0d", i), hr, exp_g[i]);
    end
    hv = 2'b00; rdy = 1'b0;

    // 3: host1 write; request changes mid-BUSY must not leak downstream
    hv = 2'b10; haddr = 16'h0400; hwe = 2'b10; hwd = {32'h12345678, 32'h0}; hstb = 8'hF0;
    step();
    chk("t3_grant", grant, 2'b10);
    chk("t3_write", owr, 1'b1);
    chk("t3_addr", oaddr, 8'h04);
    chk("t3_wdata", owd, 32'h12345678);
    chk("t3_strobe", ostb, 4'hF);
    hwd = {32'hDEADBEEF, 32'h0}; haddr = 16'h0800;
    step();
    chk("t3_wdata_hold1", owd, 32'h12345678);
    chk("t3_addr_hold1", oaddr, 8'h04);
    step();
    chk("t3_wdata_hold2", owd, 32'h12345678);
    rdy = 1'b1;
    #1;
    chk("t3_hready", hr, 2'b10);
    step();
    hv = 2'b00; hwe = 2'b00; rdy = 1'b0;
    chk("t3_idle_valid", ov, 1'b0);

    // 4: SLAVE_ERROR returned to host0
    hv = 2'b01; haddr = 16'h0020;
    step();
    chk("t4_grant", grant, 2'b01);
    rdy = 1'b1; st = 2'b10; rd = 32'h55;
    #1;
    chk("t4_hstatus", hst, 4'b0010);
    chk("t4_hready", hr, 2'b01);
    chk("t4_hrdata", hrd, {32'h0, 32'h55});
    step();
    hv = 2'b00; rdy = 1'b0; st = 2'b00;

    // early drop of valid by host1 still completes and still gets ready
    hv = 2'b10;
    step();
    chk("ed_grant", grant, 2'b10);
    hv = 2'b00;
    step();
    chk("ed_valid_held", ov, 1'b1);
    rdy = 1'b1;
    #1;
    chk("ed_hready", hr, 2'b10);
    step();
    rdy = 1'b0;

    // 5: reset during BUSY, then simultaneous request goes to host0
    hv = 2'b10;
    step();
    chk("t5_grant_pre", grant, 2'b10);
    step();
    rst = 1'b1; rdy = 1'b1;
    step();
    chk("t5_rst_valid", ov, 1'b0);
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_hready", hr, 2'b00);
    rst = 1'b0; rdy = 1'b0; hv = 2'b11;
    step();
    chk("t5_grant_after", grant, 2'b01);
    rdy = 1'b1;
    step();
    hv = 2'b00; rdy = 1'b0;

    // 6: HOSTS=3, after host2 wins, hosts 0 and 2 pending -> host0, then host2
    h3v = 3'b100;
    step();
    chk("t6_grant_h2", g3, 3'b100);
    rdy3 = 1'b1;
    step();
    chk("t6_idle1", g3, 3'b000);
    rdy3 = 1'b0; h3v = 3'b101; h3addr = 24'h320030;
    step();
    chk("t6_grant_h0", g3, 3'b001);
    chk("t6_addr_h0", oaddr3, 8'h30);
    rdy3 = 1'b1;
    step();
    chk("t6_idle2", g3, 3'b000);
    rdy3 = 1'b0;
    step();
    chk("t6_grant_h2b", g3, 3'b100);
    chk("t6_addr_h2", oaddr3, 8'h32);
    rdy3 = 1'b1;
    step();
    h3v = 3'b000; rdy3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
